state_packet_tx: RTL and testbench

Generalised game-state transmitter. It collects `NUM_FIELDS` independently-arriving state fields (player FSM data, location, etc.), each with its own valid strobe. Once every field has a fresh value, or on a forced send, it snapshots all fields into one frame with a sequence number and checksum. It then shifts that frame out MSB-first over a 3-wire SPI link to the peer board, with a parametrised bit period and a post-frame gap.

---
 rtl/state_packet_tx_pkg.sv | 27 ++
 rtl/state_packet_tx_spi_shifter.sv | 71 +++++++
 rtl/state_packet_tx.sv | 140 ++++++++++++++
 tb/tb_state_packet_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/state_packet_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : state_packet_tx_pkg
// Description : Shared types, FSM encodings and frame sizing helper for the
//               game-state packet transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package state_packet_tx_pkg;

    typedef logic [31:0] data_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } location_t;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    // Frame is {seq, fields, 8-bit checksum}.
    function automatic int frame_width(input int seq_w, input int num_fields, input int field_w);
        return seq_w + num_fields * field_w + 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/state_packet_tx_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module      : state_packet_tx_spi_shifter
// Description : Shifts one frame out MSB-first with a fixed bit period;
//               generates the SPI clock and active-low select.
// Revision    : 1.0 - initial release
// ============================================================================
module state_packet_tx_spi_shifter #(
    parameter int FRAME_W     = 48,
    parameter int DATA_PERIOD = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [FRAME_W-1:0] i_frame,
    output logic               o_done,
    output logic               o_data,
    output logic               o_sclk,
    output logic               o_sel
);

    localparam int c_PER_W = $clog2(DATA_PERIOD);
    localparam int c_BIT_W = $clog2(FRAME_W);
    localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(DATA_PERIOD - 1);
    localparam logic [c_PER_W-1:0] c_PER_HALF = c_PER_W'(DATA_PERIOD / 2);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(FRAME_W - 1);

    logic [FRAME_W-1:0] r_shift;
    logic [c_PER_W-1:0] r_per_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic               r_active;
    logic               w_bit_end;
    logic               w_last_bit;

    assign w_bit_end  = r_active && (r_per_cnt == c_PER_LAST);
    assign w_last_bit = w_bit_end && (r_bit_cnt == c_BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_per_cnt <= '0;
            r_bit_cnt <= '0;
            r_active  <= 1'b0;
        end else if (i_load && !r_active) begin
            r_shift   <= i_frame;
            r_per_cnt <= '0;
            r_bit_cnt <= '0;
            r_active  <= 1'b1;
        end else if (r_active) begin
            if (w_bit_end) begin
                // Data moves only at a bit boundary; receiver samples mid-bit.
                r_per_cnt <= '0;
                r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                if (w_last_bit) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end else begin
                r_per_cnt <= r_per_cnt + 1'b1;
            end
        end
    end

    assign o_done = w_last_bit;
    assign o_data = r_active & r_shift[FRAME_W-1];
    assign o_sclk = r_active && (r_per_cnt >= c_PER_HALF);
    assign o_sel  = ~r_active;

endmodule
`default_nettype wire

// File: rtl/state_packet_tx.sv
`default_nettype none
// ============================================================================
// Module      : state_packet_tx
// Description : Latches independently-arriving state fields and sends them as
//               a sequenced, checksummed frame over a 3-wire SPI link.
// Revision    : 1.0 - initial release
// ============================================================================
module state_packet_tx
    import state_packet_tx_pkg::*;
#(
    parameter int NUM_FIELDS  = 2,
    parameter int FIELD_WIDTH = 32,
    parameter int DATA_PERIOD = 100,
    parameter int SEQ_WIDTH   = 8
) (
    input  logic                              clk_pixel_in,
    input  logic                              rst_in,
    input  logic [NUM_FIELDS*FIELD_WIDTH-1:0] field_in,
    input  logic [NUM_FIELDS-1:0]             field_valid_in,
    input  logic                              force_in,
    output logic                              data_out,
    output logic                              data_clk_out,
    output logic                              sel_out,
    output logic                              busy_out,
    output logic                              frame_done_out,
    output logic [SEQ_WIDTH-1:0]              seq_out
);

    localparam int c_FRAME_W   = frame_width(SEQ_WIDTH, NUM_FIELDS, FIELD_WIDTH);
    localparam int c_PAYLOAD_W = SEQ_WIDTH + NUM_FIELDS * FIELD_WIDTH;
    localparam int c_NUM_BYTES = c_PAYLOAD_W / 8;
    localparam int c_GAP_W     = $clog2(DATA_PERIOD);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(DATA_PERIOD - 1);

    logic [NUM_FIELDS*FIELD_WIDTH-1:0] r_fields;
    logic [NUM_FIELDS-1:0]             r_fresh;
    logic [SEQ_WIDTH-1:0]              r_seq;
    logic [1:0]                        r_state;
    logic [c_GAP_W-1:0]                r_gap_cnt;

    logic [1:0]             w_next_state;
    logic                   w_trigger;
    logic                   w_load;
    logic                   w_busy;
    logic                   w_frame_done;
    logic                   w_shift_done;
    logic [c_PAYLOAD_W-1:0] w_payload;
    logic [7:0]             w_csum;
    logic [c_FRAME_W-1:0]   w_frame;

    assign w_trigger = (r_state == c_ST_IDLE) && ((&r_fresh) || force_in);

    // A strobe coinciding with the snapshot keeps its flag for the next frame.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            r_fresh <= '0;
        end else begin
            r_fresh <= (w_trigger ? '0 : r_fresh) | field_valid_in;
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (field_valid_in[k]) begin
                r_fields[k*FIELD_WIDTH +: FIELD_WIDTH] <= field_in[k*FIELD_WIDTH +: FIELD_WIDTH];
            end
        end
    end

    assign w_payload = {r_seq, r_fields};

    always_comb begin
        w_csum = '0;
        for (int i = 0; i < c_NUM_BYTES; i++) begin
            w_csum = w_csum + w_payload[i*8 +: 8];
        end
    end

    assign w_frame = {w_payload, w_csum};

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_trigger)                 w_next_state = c_ST_SHIFT;
            c_ST_SHIFT: if (w_shift_done)              w_next_state = c_ST_GAP;
            c_ST_GAP:   if (r_gap_cnt == c_GAP_LAST)   w_next_state = c_ST_IDLE;
            default:                                   w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy       = (r_state != c_ST_IDLE);
        w_load       = w_trigger;
        w_frame_done = (r_state == c_ST_GAP) && (r_gap_cnt == c_GAP_LAST);
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in || (r_state != c_ST_GAP)) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            r_seq <= '0;
        end else if (w_frame_done) begin
            r_seq <= r_seq + 1'b1;
        end
    end

    state_packet_tx_spi_shifter #(
        .FRAME_W     (c_FRAME_W),
        .DATA_PERIOD (DATA_PERIOD)
    ) u_shifter (
        .clk     (clk_pixel_in),
        .rst     (rst_in),
        .i_load  (w_load),
        .i_frame (w_frame),
        .o_done  (w_shift_done),
        .o_data  (data_out),
        .o_sclk  (data_clk_out),
        .o_sel   (sel_out)
    );

    assign busy_out       = w_busy;
    assign frame_done_out = w_frame_done;
    assign seq_out        = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_state_packet_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_state_packet_tx
// Description : Self-checking bench for state_packet_tx against a
//               cycle-offset reference model and an SPI receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_state_packet_tx;

    localparam int NF        = 2;
    localparam int FW        = 16;
    localparam int DP        = 4;
    localparam int SW        = 8;
    localparam int FRW       = SW + NF * FW + 8;
    localparam int FRAME_CYC = (FRW + 1) * DP;

    logic          clk_pixel_in = 1'b0;
    logic          rst_in;
    logic [31:0]   field_in;
    logic [1:0]    field_valid_in;
    logic          force_in;
    logic          data_out;
    logic          data_clk_out;
    logic          sel_out;
    logic          busy_out;
    logic          frame_done_out;
    logic [7:0]    seq_out;

    state_packet_tx #(
        .NUM_FIELDS  (NF),
        .FIELD_WIDTH (FW),
        .DATA_PERIOD (DP),
        .SEQ_WIDTH   (SW)
    ) dut (
        .clk_pixel_in   (clk_pixel_in),
        .rst_in         (rst_in),
        .field_in       (field_in),
        .field_valid_in (field_valid_in),
        .force_in       (force_in),
        .data_out       (data_out),
        .data_clk_out   (data_clk_out),
        .sel_out        (sel_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out),
        .seq_out        (seq_out)
    );

    always #5 clk_pixel_in = ~clk_pixel_in;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    // Reference model: frame timing as an offset from the trigger cycle.
    logic [15:0] m_field [NF];
    bit          m_fresh [NF];
    logic [7:0]  m_seq    = '0;
    bit          m_active = 1'b0;
    int          m_d      = 0;
    logic [47:0] m_frame  = '0;
    logic [47:0] exp_q [$];
    int          done_cnt = 0;

    function automatic logic [47:0] make_frame(input logic [7:0] s, input logic [15:0] f1,
                                               input logic [15:0] f0);
        logic [7:0] cs;
        cs = s + f1[15:8] + f1[7:0] + f0[15:8] + f0[7:0];
        return {s, f1, f0, cs};
    endfunction

    task automatic model_edge();
        bit trig;
        trig = !rst_in && !m_active && ((m_fresh[0] && m_fresh[1]) || force_in);
        if (rst_in) begin
            m_active = 1'b0;
            m_seq    = '0;
            m_fresh[0] = 1'b0;
            m_fresh[1] = 1'b0;
            exp_q.delete();
        end else begin
            if (trig) begin
                m_frame = make_frame(m_seq, m_field[1], m_field[0]);
                exp_q.push_back(m_frame);
                m_fresh[0] = 1'b0;
                m_fresh[1] = 1'b0;
                m_active   = 1'b1;
                m_d        = 1;
            end else if (m_active) begin
                m_d++;
                if (m_d == FRAME_CYC + 1) begin
                    m_active = 1'b0;
                    m_seq    = m_seq + 8'd1;
                end
            end
            for (int k = 0; k < NF; k++) begin
                if (field_valid_in[k]) begin
                    m_field[k] = field_in[k*FW +: FW];
                    m_fresh[k] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [12:0] model_outputs();
        logic sel, sclk, dat, busy, done;
        int   idx, phase;
        sel = 1'b1; sclk = 1'b0; dat = 1'b0; busy = 1'b0; done = 1'b0;
        if (m_active) begin
            busy = 1'b1;
            done = (m_d == FRAME_CYC);
            if (m_d <= FRW * DP) begin
                idx   = (m_d - 1) / DP;
                phase = (m_d - 1) % DP;
                sel   = 1'b0;
                dat   = m_frame[FRW-1-idx];
                sclk  = (phase >= DP / 2);
            end
        end
        return {sel, sclk, dat, busy, done, m_seq};
    endfunction

    task automatic tick();
        @(posedge clk_pixel_in);
        model_edge();
        #1;
        if (frame_done_out === 1'b1) done_cnt++;
        check("outputs", {sel_out, data_clk_out, data_out, busy_out, frame_done_out, seq_out},
              model_outputs());
        if (n_err > 50) finish_run();
    endtask

    task automatic wait_idle();
        int i;
        tick();
        for (i = 0; i < 1000 && (m_active || busy_out); i++) tick();
        check("idle_reached", (i < 1000), 1);
    endtask

    // SPI receiver: samples on rising clock, compares at select release.
    logic [47:0] rx_sh      = '0;
    logic [47:0] last_rx    = '0;
    int          rx_n       = 0;
    bit          rx_discard = 1'b0;

    always @(negedge sel_out) begin
        rx_n       = 0;
        rx_discard = 1'b0;
    end

    always @(posedge data_clk_out) begin
        rx_sh = {rx_sh[46:0], data_out};
        rx_n++;
    end

    always @(posedge sel_out) begin
        if (!rx_discard && (rx_n != 0 || exp_q.size() != 0)) begin
            last_rx = rx_sh;
            check("rx_bits", rx_n, FRW);
            if (exp_q.size() == 0) begin
                check("rx_unexpected_frame", 1, 0);
            end else begin
                check("rx_frame", rx_sh, exp_q.pop_front());
            end
        end
    end

    initial begin
        int lo;
        int dc;
        int target;
        int i;
        logic [7:0] seq0;

        rst_in = 1'b1; field_in = '0; field_valid_in = '0; force_in = 1'b0;
        repeat (3) tick();
        check("reset_state", {sel_out, busy_out, frame_done_out, seq_out, data_out, data_clk_out},
              {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        rst_in = 1'b0;
        tick();

        // Basic frame
        field_in[15:0] = 16'h1234; field_valid_in = 2'b01; tick();
        field_valid_in = 2'b00; tick(); tick();
        field_in[31:16] = 16'hABCD; field_valid_in = 2'b10; tick();
        field_valid_in = 2'b00;
        check("sel_before_trigger", sel_out, 1'b1);
        tick();
        check("sel_fall", sel_out, 1'b0);
        lo = 1;
        for (i = 0; i < 400 && !sel_out; i++) begin
            tick();
            if (!sel_out) lo++;
        end
        check("sel_low_cycles", lo, FRW * DP);
        wait_idle();
        check("basic_frame", last_rx, 48'h00ABCD1234BE);
        check("basic_done_count", done_cnt, 1);
        check("basic_seq", seq_out, 8'h01);

        // Partial then forced
        field_in[15:0] = 16'h5555; field_valid_in = 2'b01; tick();
        field_valid_in = 2'b00;
        repeat (20) tick();
        check("no_partial_frame", busy_out, 1'b0);
        force_in = 1'b1; tick(); force_in = 1'b0;
        wait_idle();
        check("forced_frame", last_rx, 48'h01ABCD555523);
        repeat (20) tick();
        check("fresh_cleared", busy_out, 1'b0);

        // Update during SHIFT, back-to-back frame
        field_in = {16'h2222, 16'h1111}; field_valid_in = 2'b11; tick();
        field_valid_in = 2'b00;
        repeat (30) tick();
        field_in[15:0] = 16'h3333; field_valid_in = 2'b01; tick();
        field_in[31:16] = 16'h4444; field_valid_in = 2'b10; force_in = 1'b1; tick();
        field_valid_in = 2'b00; force_in = 1'b0;
        wait_idle();
        check("upd_frame1", last_rx[39:8], {16'h2222, 16'h1111});
        tick();
        check("b2b_start", busy_out, 1'b1);
        wait_idle();
        check("upd_frame2", last_rx[39:8], {16'h4444, 16'h3333});

        // Valid in the same cycle as the trigger
        field_in[15:0] = 16'h0A0A; field_valid_in = 2'b01; tick();
        field_in[31:16] = 16'h0B0B; field_valid_in = 2'b10; tick();
        field_in[15:0] = 16'h0C0C; field_valid_in = 2'b01; tick();
        field_valid_in = 2'b00;
        wait_idle();
        check("same_cycle_frame1", last_rx[39:8], {16'h0B0B, 16'h0A0A});
        repeat (10) tick();
        check("single_fresh_waits", busy_out, 1'b0);
        field_in[31:16] = 16'h0D0D; field_valid_in = 2'b10; tick();
        field_valid_in = 2'b00;
        wait_idle();
        check("same_cycle_frame2", last_rx[39:8], {16'h0D0D, 16'h0C0C});

        // Randomized traffic across a full sequence wrap
        target = done_cnt + 256;
        seq0   = seq_out;
        for (i = 0; i < 60000 && done_cnt < target; i++) begin
            field_in       = $urandom;
            field_valid_in = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            force_in       = ($urandom_range(0, 63) == 0);
            tick();
        end
        field_valid_in = 2'b00; force_in = 1'b0;
        tick();
        check("wrap_frames", done_cnt, target);
        check("wrap_seq", seq_out, seq0);
        wait_idle();

        // Reset in the middle of bit 20
        field_in = {16'h8888, 16'h7777}; field_valid_in = 2'b11; tick();
        field_valid_in = 2'b00;
        for (i = 0; i < 1000 && !(m_active && m_d == 20 * DP + 1); i++) tick();
        check("bit20_reached", (i < 1000), 1);
        dc = done_cnt;
        rx_discard = 1'b1;
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        check("rst_sel", sel_out, 1'b1);
        check("rst_seq", seq_out, 8'h00);
        check("rst_busy", busy_out, 1'b0);
        repeat (FRAME_CYC + 10) tick();
        check("rst_no_done", done_cnt, dc);
        field_in[15:0] = 16'h9999; field_valid_in = 2'b01; tick();
        field_valid_in = 2'b00;
        repeat (30) tick();
        check("rst_needs_both", busy_out, 1'b0);
        field_in[31:16] = 16'hAAAA; field_valid_in = 2'b10; tick();
        field_valid_in = 2'b00;
        wait_idle();
        check("post_rst_frame", last_rx, 48'h00AAAA999986);

        finish_run();
    end

endmodule
`default_nettype wire
